apb_simple_master: RTL and testbench



---
 rtl/apb_simple_master.sv | 176 +++++++++++++++++
 tb/tb_apb_simple_master.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_simple_master.sv
// Single-outstanding APB3 initiator: valid/ready request in, one APB transfer, valid/ready response out.
// Optional ACCESS-phase watchdog enabled by defining APB_SIMPLE_MASTER_TIMEOUT_EN.
module apb_simple_master #(
  parameter int APB_ADDR_WIDTH = 12,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                      HCLK,
  input  logic                      HRESETn,
  input  logic                      req_valid_i,
  output logic                      req_ready_o,
  input  logic [APB_ADDR_WIDTH-1:0] req_addr_i,
  input  logic                      req_write_i,
  input  logic [31:0]               req_wdata_i,
  output logic                      resp_valid_o,
  input  logic                      resp_ready_i,
  output logic [31:0]               resp_rdata_o,
  output logic                      resp_err_o,
  output logic                      resp_timeout_o,
  output logic                      busy_o,
  output logic [APB_ADDR_WIDTH-1:0] PADDR,
  output logic [31:0]               PWDATA,
  output logic                      PWRITE,
  output logic                      PSEL,
  output logic                      PENABLE,
  input  logic [31:0]               PRDATA,
  input  logic                      PREADY,
  input  logic                      PSLVERR
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS,
    RESP
  } state_e;

  state_e                      state_q, state_d;
  logic [APB_ADDR_WIDTH-1:0]   paddr_q, paddr_d;
  logic [31:0]                 pwdata_q, pwdata_d;
  logic                        pwrite_q, pwrite_d;
  logic                        psel_q, psel_d;
  logic                        penable_q, penable_d;
  logic                        rvalid_q, rvalid_d;
  logic [31:0]                 rdata_q, rdata_d;
  logic                        err_q, err_d;

`ifdef APB_SIMPLE_MASTER_TIMEOUT_EN
  logic [CW-1:0]               cnt_q, cnt_d;
  logic                        tmo_q, tmo_d;
`endif

  // Next-state and registered-output computation for the transfer FSM
  always_comb begin
    state_d   = state_q;
    paddr_d   = paddr_q;
    pwdata_d  = pwdata_q;
    pwrite_d  = pwrite_q;
    psel_d    = psel_q;
    penable_d = penable_q;
    rvalid_d  = rvalid_q;
    rdata_d   = rdata_q;
    err_d     = err_q;
`ifdef APB_SIMPLE_MASTER_TIMEOUT_EN
    cnt_d     = cnt_q;
    tmo_d     = tmo_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (req_valid_i) begin
          paddr_d   = {req_addr_i[APB_ADDR_WIDTH-1:2], 2'b00};
          pwdata_d  = req_wdata_i;
          pwrite_d  = req_write_i;
          psel_d    = 1'b1;
          penable_d = 1'b0;
          state_d   = SETUP;
        end
      end
      SETUP: begin
        penable_d = 1'b1;
        state_d   = ACCESS;
`ifdef APB_SIMPLE_MASTER_TIMEOUT_EN
        cnt_d     = '0;
`endif
      end
      ACCESS: begin
        if (PREADY) begin
          rdata_d   = pwrite_q ? 32'h0 : PRDATA;
          err_d     = PSLVERR;
          psel_d    = 1'b0;
          penable_d = 1'b0;
          rvalid_d  = 1'b1;
          state_d   = RESP;
`ifdef APB_SIMPLE_MASTER_TIMEOUT_EN
          tmo_d     = 1'b0;
        end else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
          rdata_d   = 32'hDEADBEEF;
          err_d     = 1'b1;
          tmo_d     = 1'b1;
          psel_d    = 1'b0;
          penable_d = 1'b0;
          rvalid_d  = 1'b1;
          state_d   = RESP;
        end else begin
          cnt_d     = cnt_q + CW'(1);
`endif
        end
      end
      RESP: begin
        if (resp_ready_i) begin
          rvalid_d = 1'b0;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers, cleared asynchronously
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q   <= IDLE;
      paddr_q   <= '0;
      pwdata_q  <= '0;
      pwrite_q  <= 1'b0;
      psel_q    <= 1'b0;
      penable_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
`ifdef APB_SIMPLE_MASTER_TIMEOUT_EN
      cnt_q     <= '0;
      tmo_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      paddr_q   <= paddr_d;
      pwdata_q  <= pwdata_d;
      pwrite_q  <= pwrite_d;
      psel_q    <= psel_d;
      penable_q <= penable_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
      err_q     <= err_d;
`ifdef APB_SIMPLE_MASTER_TIMEOUT_EN
      cnt_q     <= cnt_d;
      tmo_q     <= tmo_d;
`endif
    end
  end

  assign req_ready_o  = (state_q == IDLE);
  assign busy_o       = (state_q != IDLE);
  assign PADDR        = paddr_q;
  assign PWDATA       = pwdata_q;
  assign PWRITE       = pwrite_q;
  assign PSEL         = psel_q;
  assign PENABLE      = penable_q;
  assign resp_valid_o = rvalid_q;
  assign resp_rdata_o = rdata_q;
  assign resp_err_o   = err_q;

`ifdef APB_SIMPLE_MASTER_TIMEOUT_EN
  assign resp_timeout_o = tmo_q;
  logic unused_ok;
  assign unused_ok = ^req_addr_i[1:0];
`else
  assign resp_timeout_o = 1'b0;
  logic [CW-1:0] unused_tmo;
  logic          unused_ok;
  assign unused_tmo = CW'(TIMEOUT_CYCLES);
  assign unused_ok  = ^{req_addr_i[1:0], unused_tmo};
`endif

endmodule

// File: tb/tb_apb_simple_master.sv
// Randomized bench for apb_simple_master with a cycle-index reference model.
// Watchdog scenarios run when APB_SIMPLE_MASTER_TIMEOUT_EN is defined.
module tb_apb_simple_master;

  localparam int AW  = 12;
  localparam int TMO = 4;
`ifdef APB_SIMPLE_MASTER_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [AW-1:0] req_addr = '0;
  logic          req_write = 1'b0;
  logic [31:0]   req_wdata = '0;
  logic          resp_valid;
  logic          resp_ready = 1'b0;
  logic [31:0]   resp_rdata;
  logic          resp_err;
  logic          resp_tmo;
  logic          busy;
  logic [AW-1:0] paddr;
  logic [31:0]   pwdata;
  logic          pwrite;
  logic          psel;
  logic          penable;
  logic [31:0]   prdata = '0;
  logic          pready = 1'b0;
  logic          pslverr = 1'b0;

  apb_simple_master #(
    .APB_ADDR_WIDTH(AW),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .HCLK(clk),
    .HRESETn(rst_n),
    .req_valid_i(req_valid),
    .req_ready_o(req_ready),
    .req_addr_i(req_addr),
    .req_write_i(req_write),
    .req_wdata_i(req_wdata),
    .resp_valid_o(resp_valid),
    .resp_ready_i(resp_ready),
    .resp_rdata_o(resp_rdata),
    .resp_err_o(resp_err),
    .resp_timeout_o(resp_tmo),
    .busy_o(busy),
    .PADDR(paddr),
    .PWDATA(pwdata),
    .PWRITE(pwrite),
    .PSEL(psel),
    .PENABLE(penable),
    .PRDATA(prdata),
    .PREADY(pready),
    .PSLVERR(pslverr)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
  endfunction

  // Reference model: m_k is the cycle index since the accept edge.
  bit          m_busy, m_respv, m_err, m_tmo, m_write;
  int          m_k;
  logic [AW-1:0] m_addr;
  logic [31:0] m_wdata, m_rdata;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy <= 0; m_respv <= 0; m_k <= 0;
      m_addr <= '0; m_wdata <= '0; m_write <= 0;
      m_rdata <= '0; m_err <= 0; m_tmo <= 0;
    end else if (m_respv) begin
      if (resp_ready) m_respv <= 0;
    end else if (m_busy) begin
      if (m_k >= 2 && pready) begin
        m_busy <= 0; m_respv <= 1;
        m_rdata <= m_write ? 32'h0 : prdata;
        m_err <= pslverr; m_tmo <= 0;
      end else if (TMO_EN && m_k >= 2 && (m_k - 1) == TMO) begin
        m_busy <= 0; m_respv <= 1;
        m_rdata <= 32'hDEADBEEF; m_err <= 1; m_tmo <= 1;
      end else begin
        m_k <= m_k + 1;
      end
    end else if (req_valid) begin
      m_busy <= 1; m_k <= 1;
      m_addr <= req_addr & ~AW'(3);
      m_wdata <= req_wdata; m_write <= req_write;
    end
  end

  // Compare every DUT output against the model each cycle
  always @(negedge clk) begin
    chk("req_ready", 32'(req_ready), 32'(!m_busy && !m_respv));
    chk("busy", 32'(busy), 32'(m_busy || m_respv));
    chk("psel", 32'(psel), 32'(m_busy));
    chk("penable", 32'(penable), 32'(m_busy && m_k >= 2));
    chk("paddr", 32'(paddr), 32'(m_addr));
    chk("pwdata", pwdata, m_wdata);
    chk("pwrite", 32'(pwrite), 32'(m_write));
    chk("resp_valid", 32'(resp_valid), 32'(m_respv));
    chk("resp_rdata", resp_rdata, m_rdata);
    chk("resp_err", 32'(resp_err), 32'(m_err));
    chk("resp_tmo", 32'(resp_tmo), 32'(m_tmo));
  end

  // Slave: completes after s_wait ACCESS wait states, noise elsewhere
  int          s_wait = 0;
  logic [31:0] s_rdata = '0;
  logic        s_err = 1'b0;

  always @(negedge clk) begin
    if (m_busy && m_k >= 2) begin
      pready  = (m_k - 2) >= s_wait;
      prdata  = pready ? s_rdata : $urandom;
      pslverr = pready ? s_err : 1'($urandom);
    end else begin
      pready  = 1'($urandom);
      prdata  = $urandom;
      pslverr = 1'($urandom);
    end
  end

  task automatic issue(input logic [AW-1:0] a, input logic w,
                       input logic [31:0] d);
    @(negedge clk);
    req_addr = a; req_write = w; req_wdata = d; req_valid = 1'b1;
    for (int c = 0; c < 50 && !m_busy; c++) @(negedge clk);
    chk("accept_wait", 32'(m_busy), 32'd1);
    req_valid = 1'b0;
  endtask

  task automatic finish_resp(input int dly);
    for (int c = 0; c < 2000 && !m_respv; c++) @(negedge clk);
    chk("resp_wait", 32'(m_respv), 32'd1);
    repeat (dly) @(negedge clk);
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_psel", 32'(psel), 32'd0);
    chk("rst_rvalid", 32'(resp_valid), 32'd0);
    chk("rst_paddr", 32'(paddr), 32'd0);
    chk("rst_ready", 32'(req_ready), 32'd1);
    rst_n = 1'b1;

    // Read, zero wait states
    s_wait = 0; s_rdata = 32'h00040001; s_err = 0;
    issue(12'h000, 1'b0, 32'h0);
    chk("t1_c1_psel", 32'(psel), 32'd1);
    chk("t1_c1_pen", 32'(penable), 32'd0);
    @(negedge clk);
    chk("t1_c2_pen", 32'(penable), 32'd1);
    @(negedge clk);
    chk("t1_c3_valid", 32'(resp_valid), 32'd1);
    chk("t1_c3_psel", 32'(psel), 32'd0);
    chk("t1_rdata", resp_rdata, 32'h00040001);
    chk("t1_err", 32'(resp_err), 32'd0);
    finish_resp(0);

    // Write, two wait states
    s_wait = 2; s_rdata = 32'h55AA55AA;
    issue(12'h0C6, 1'b1, 32'h1A000080);
    for (int c = 1; c <= 4; c++) begin
      chk("t2_paddr", 32'(paddr), 32'h0C4);
      chk("t2_pwdata", pwdata, 32'h1A000080);
      @(negedge clk);
    end
    chk("t2_c5_valid", 32'(resp_valid), 32'd1);
    chk("t2_rdata", resp_rdata, 32'h0);
    finish_resp(0);

    // Read with slave error
    s_wait = 1; s_rdata = 32'hDEADBEEF; s_err = 1;
    issue(12'h010, 1'b0, 32'h0);
    for (int c = 0; c < 20 && !m_respv; c++) @(negedge clk);
    chk("t3_err", 32'(resp_err), 32'd1);
    chk("t3_rdata", resp_rdata, 32'hDEADBEEF);
    chk("t3_tmo", 32'(resp_tmo), 32'd0);
    finish_resp(0);

    // Back-pressure with a held follow-on request
    s_wait = 0; s_err = 0; s_rdata = 32'hCAFE0001;
    issue(12'h020, 1'b0, 32'h0);
    req_addr = 12'h024; req_write = 1'b1; req_wdata = 32'h77; req_valid = 1'b1;
    for (int c = 0; c < 20 && !m_respv; c++) @(negedge clk);
    for (int c = 0; c < 10; c++) begin
      chk("t4_ready_low", 32'(req_ready), 32'd0);
      chk("t4_rdata_hold", resp_rdata, 32'hCAFE0001);
      @(negedge clk);
    end
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    chk("t4_gap_psel", 32'(psel), 32'd0);
    @(negedge clk);
    chk("t4_setup_psel", 32'(psel), 32'd1);
    chk("t4_setup_pen", 32'(penable), 32'd0);
    req_valid = 1'b0;
    finish_resp(0);

`ifdef APB_SIMPLE_MASTER_TIMEOUT_EN
    s_wait = 100000;
    issue(12'h030, 1'b0, 32'h0);
    repeat (4) @(negedge clk);
    chk("to_c5_psel", 32'(psel), 32'd1);
    @(negedge clk);
    chk("to_c6_psel", 32'(psel), 32'd0);
    chk("to_err", 32'(resp_err), 32'd1);
    chk("to_tmo", 32'(resp_tmo), 32'd1);
    chk("to_rdata", resp_rdata, 32'hDEADBEEF);
    finish_resp(0);
    s_wait = 3; s_rdata = 32'h0BADF00D;
    issue(12'h034, 1'b0, 32'h0);
    repeat (5) @(negedge clk);
    chk("to4_tmo", 32'(resp_tmo), 32'd0);
    chk("to4_rdata", resp_rdata, 32'h0BADF00D);
    finish_resp(0);
`endif

    // Randomized transfers
    for (int i = 0; i < 40; i++) begin
      s_wait  = $urandom_range(0, 3);
      s_err   = 1'($urandom);
      s_rdata = $urandom;
      issue(AW'($urandom), 1'($urandom), $urandom);
      finish_resp($urandom_range(0, 3));
    end

    // Reset in the middle of ACCESS
    s_wait = 5; s_err = 0;
    issue(12'h040, 1'b0, 32'h0);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("mr_psel", 32'(psel), 32'd0);
    chk("mr_pen", 32'(penable), 32'd0);
    chk("mr_rvalid", 32'(resp_valid), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("mr_ready", 32'(req_ready), 32'd1);
    s_wait = 0; s_rdata = 32'h12345678;
    issue(12'h044, 1'b0, 32'h0);
    for (int c = 0; c < 20 && !m_respv; c++) @(negedge clk);
    chk("mr_rdata", resp_rdata, 32'h12345678);
    finish_resp(0);

    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
